// File: rtl/riscv_div_pkg.sv
// Shared encodings for the RV32M iterative divider: funct3 opcodes, FSM states
// and the most-negative 32-bit integer used for overflow detection.
package riscv_div_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step_32.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference and set the quotient LSB when no borrow.
module div_step_32 (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        borrow;

    // rem < divisor always holds, so a set shifted[32] means the subtraction
    // cannot underflow and bit 32 of the 33-bit difference is a true borrow.
    assign shifted  = {rem, quo[31]};
    assign trial    = shifted - {1'b0, divisor};
    assign borrow   = trial[32];
    assign rem_next = borrow ? shifted[31:0] : trial[31:0];
    assign quo_next = {quo[30:0], ~borrow};

endmodule

// File: rtl/riscv_divider_32.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: 32 restoring steps on magnitudes,
// sign fix-up on the final load, single-cycle fast path for b==0 and overflow.
module riscv_divider_32
    import riscv_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_t  state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] dvsr_reg;
    logic [2:0]  f3_reg;
    logic        neg_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] result_reg;

    logic        is_signed;
    logic        is_rem;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        overflow;
    logic [31:0] fast_result;
    logic        neg_next;

    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic        f3_is_rem;
    logic [31:0] final_mag;
    logic [31:0] final_result;

    // Undefined funct3 encodings fall through to DIVU behaviour.
    assign is_signed   = (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign is_rem      = (funct3 == F3_REM) || (funct3 == F3_REMU);
    assign a_mag       = (is_signed && a[31]) ? -a : a;
    assign b_mag       = (is_signed && b[31]) ? -b : b;
    assign div_zero    = (b == '0);
    assign overflow    = is_signed && (a == INT_MIN) && (&b);
    assign fast_result = div_zero ? (is_rem ? a : '1) : (is_rem ? '0 : INT_MIN);
    assign neg_next    = is_signed && (is_rem ? a[31] : (a[31] ^ b[31]));

    div_step_32 u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (dvsr_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign f3_is_rem    = (f3_reg == F3_REM) || (f3_reg == F3_REMU);
    assign final_mag    = f3_is_rem ? step_rem : step_quo;
    assign final_result = neg_reg ? -final_mag : final_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvsr_reg   <= '0;
            f3_reg     <= '0;
            neg_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        f3_reg  <= funct3;
                        neg_reg <= neg_next;
                        if (div_zero || overflow) begin
                            result_reg <= fast_result;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            rem_reg   <= '0;
                            quo_reg   <= a_mag;
                            dvsr_reg  <= b_mag;
                            cnt_reg   <= 5'd31;
                            busy_reg  <= 1'b1;
                            state_reg <= CALC;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    quo_reg <= step_quo;
                    cnt_reg <= cnt_reg - 5'd1;
                    if (cnt_reg == 5'd0) begin
                        result_reg <= final_result;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_riscv_divider_32.sv
// Directed and randomized checks of riscv_divider_32 against a plain-arithmetic
// RV32M reference, including latency, flush, reset and back-to-back behaviour.
module tb_riscv_divider_32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    riscv_divider_32 #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct3  (funct3),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Architectural RV32M result and expected start-to-done latency in cycles.
    function automatic void model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output int lat);
        bit s;
        bit isrem;
        int sx;
        int sy;
        s     = (f3 == 3'b100) || (f3 == 3'b110);
        isrem = (f3 == 3'b110) || (f3 == 3'b111);
        sx    = x;
        sy    = y;
        if (y == 32'd0) begin
            r   = isrem ? x : 32'hFFFF_FFFF;
            lat = 1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r   = isrem ? 32'd0 : 32'h8000_0000;
            lat = 1;
        end else begin
            lat = 33;
            if (s) r = isrem ? 32'(sx % sy) : 32'(sx / sy);
            else   r = isrem ? (x % y) : (x / y);
        end
    endfunction

    // Entered at a negedge; returns at the negedge of the done cycle so that a
    // following call issues its start in the done cycle (back-to-back).
    task automatic do_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] expv;
        int          lat;
        int          n;
        string       tag;
        model(f3, x, y, expv, lat);
        tag    = $sformatf("f3=%03b a=%08h b=%08h", f3, x, y);
        start  = 1'b1;
        funct3 = f3;
        a      = x;
        b      = y;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        a      = $urandom;
        b      = $urandom;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " result"}, result, expv);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        $display("[TB] op %s -> result=%08h latency=%0d", tag, result, n);
    endtask

    initial begin
        int early;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'b000;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases; the first pairs also run back-to-back.
        do_op(3'b101, 32'd100, 32'd7);
        do_op(3'b111, 32'd100, 32'd7);
        @(negedge clk);
        check("done single pulse", 32'(done), 32'd0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        do_op(3'b100, 32'h1234, 32'd0);
        do_op(3'b101, 32'h1234, 32'd0);
        do_op(3'b111, 32'h1234, 32'd0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'b110, 32'h1234, 32'd0);
        do_op(3'b000, 32'd1000, 32'd3);
        @(negedge clk);

        // Flush mid-operation, then a new DIVU 9/3 started at cycle k+12.
        start  = 1'b1;
        funct3 = 3'b101;
        a      = 32'hFFFF_FFFF;
        b      = 32'd1;
        @(posedge clk);
        @(negedge clk);
        early = 0;
        for (int n = 1; n <= 44; n++) begin
            if (done === 1'b1) early++;
            if (n == 11) check("flush busy drop", 32'(busy), 32'd0);
            flush = (n == 10);
            if (n == 12) begin
                start  = 1'b1;
                funct3 = 3'b101;
                a      = 32'd9;
                b      = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("flush no early done", 32'(early), 32'd0);
        check("flush second done", 32'(done), 32'd1);
        check("flush second result", result, 32'd3);
        $display("[TB] flush sequence done=%0b result=%08h", done, result);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        start  = 1'b1;
        funct3 = 3'b101;
        a      = 32'hDEAD_BEEF;
        b      = 32'd13;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midop reset busy", 32'(busy), 32'd0);
        check("midop reset done", 32'(done), 32'd0);
        check("midop reset result", result, 32'd0);
        $display("[TB] mid-op reset busy=%0b done=%0b result=%08h", busy, done, result);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op(3'b101, 32'hDEAD_BEEF, 32'd13);
        @(negedge clk);

        // Randomized operations with corner-case biasing.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] x;
            logic [31:0] y;
            int          sel;
            f3  = 3'($urandom_range(0, 7));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'd0;
            else if (sel == 1) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end else if (sel == 2) y = 32'($urandom_range(1, 20));
            else if (sel == 3) y = -32'($urandom_range(1, 20));
            do_op(f3, x, y);
            @(negedge clk);
            check("random done pulse", 32'(done), 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
